// File: rtl/calc_pkg.sv
// calc_pkg -- shared definitions for the result display slice.
//   state_e   : conversion FSM states (idle / double-dabble in progress)
//   SEG_0..9  : seven-segment patterns {g,f,e,d,c,b,a}, active-low
//   SEG_BLANK : all segments off
package calc_pkg;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_CONVERT = 1'b1
   } state_e;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode -- combinational BCD to seven-segment lookup.
//   bcd_i   : BCD digit 0..9 (codes 10..15 show blank)
//   blank_i : force all segments off
//   seg_o   : segments {g,f,e,d,c,b,a}, active-low
module seg7_decode
   import calc_pkg::*;
(
   input  logic [3:0] bcd_i,
   input  logic       blank_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = SEG_BLANK;
      if (!blank_i) begin
         case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
         endcase
      end
   end

endmodule

// File: rtl/result_display.sv
// result_display -- converts a signed N-bit result to BCD (double dabble,
// one bit per clock) and drives a multiplexed seven-segment display.
//   clk    : clock, rising edge
//   reset  : asynchronous, active-high
//   load   : one-cycle strobe, captures result when not busy
//   result : signed value to display
//   busy   : conversion in progress
//   valid  : display holds a completed conversion (sticky until reset)
//   neg    : sign LED for the displayed value
//   seg    : segments {g,f,e,d,c,b,a}, active-low
//   an     : one-hot active-low digit enable, bit 0 = least significant
module result_display
   import calc_pkg::*;
#(
   parameter int N        = 8,
   parameter int DIGITS   = 3,
   parameter int SCAN_DIV = 1000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [N-1:0]      result,
   output logic              busy,
   output logic              valid,
   output logic              neg,
   output logic [6:0]        seg,
   output logic [DIGITS-1:0] an
);

   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int DSLOTS = 2 ** DW;

   state_e                  state_q;
   logic [N-1:0]            mag_q;
   logic                    sign_q;
   logic [4*DIGITS-1:0]     bcd_q;
   logic [CW-1:0]           cnt_q;
   logic [4*DIGITS-1:0]     disp_q;
   logic                    busy_q;
   logic                    valid_q;
   logic                    neg_q;
   logic [PW-1:0]           presc_q;
   logic [DW-1:0]           idx_q;

   logic [N-1:0]            mag_in;
   logic [4*DIGITS-1:0]     bcd_adj;
   logic [4*DIGITS-1:0]     bcd_d;

   // Two's-complement negate; the most negative value wraps onto itself,
   // which read as unsigned is exactly 2^(N-1).
   assign mag_in = result[N-1] ? ((~result) + N'(1)) : result;

   // Double-dabble step: correct every nibble >= 5, then shift in mag MSB.
   for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ?
                                  (bcd_q[4*gi +: 4] + 4'd3) : bcd_q[4*gi +: 4];
   end
   assign bcd_d = {bcd_adj[4*DIGITS-2:0], mag_q[N-1]};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         mag_q   <= '0;
         sign_q  <= 1'b0;
         bcd_q   <= '0;
         cnt_q   <= '0;
         disp_q  <= '0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
         neg_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (load) begin
                  mag_q   <= mag_in;
                  sign_q  <= result[N-1];
                  bcd_q   <= '0;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= ST_CONVERT;
               end
            end
            ST_CONVERT: begin
               bcd_q <= bcd_d;
               mag_q <= mag_q << 1;
               cnt_q <= cnt_q + CW'(1);
               // Final iteration: publish the freshly shifted BCD directly
               // so the display updates on the same edge.
               if (cnt_q == CW'(N - 1)) begin
                  disp_q  <= bcd_d;
                  neg_q   <= sign_q;
                  valid_q <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Digit scan: each digit stays enabled for SCAN_DIV cycles.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc_q <= '0;
         idx_q   <= '0;
      end else if (presc_q == PW'(SCAN_DIV - 1)) begin
         presc_q <= '0;
         idx_q   <= (idx_q == DW'(DIGITS - 1)) ? '0 : idx_q + DW'(1);
      end else begin
         presc_q <= presc_q + PW'(1);
      end
   end

   // Per-slot digit value and leading-zero blanking. A digit above 0 is a
   // leading zero when it and every more significant digit are zero.
   // Slots past DIGITS exist only to make the index table a power of two.
   logic [3:0] digit_w      [DSLOTS];
   logic       lead_blank_w [DSLOTS];

   for (genvar gi = 0; gi < DSLOTS; gi++) begin : g_digit
      if (gi >= DIGITS) begin : g_unused
         assign digit_w[gi]      = 4'd0;
         assign lead_blank_w[gi] = 1'b1;
      end else if (gi == 0) begin : g_lsd
         assign digit_w[gi]      = disp_q[3:0];
         assign lead_blank_w[gi] = 1'b0;
      end else begin : g_upper
         assign digit_w[gi]      = disp_q[4*gi +: 4];
         assign lead_blank_w[gi] = (disp_q[4*DIGITS-1:4*gi] == '0);
      end
   end

   logic [3:0] digit_sel;
   logic       blank_sel;

   assign digit_sel = digit_w[idx_q];
   assign blank_sel = !valid_q || lead_blank_w[idx_q];

   seg7_decode u_seg7_decode (
      .bcd_i   (digit_sel),
      .blank_i (blank_sel),
      .seg_o   (seg)
   );

   assign an    = ~(DIGITS'(1) << idx_q);
   assign busy  = busy_q;
   assign valid = valid_q;
   assign neg   = neg_q;

endmodule
